serial_fir_bank: RTL and testbench

// - Parametrised successor to the fixed 16-channel shared-delay-line filter bank: one sample delay

---
 rtl/serial_fir_bank.sv | 139 +++++++++++++
 tb/tb_serial_fir_bank.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_fir_bank.sv
// serial_fir_bank: one shared sample delay line feeding NUM_CH FIR channels.
// Each channel owns a single multiplier and walks the TAPS coefficients
// serially, one tap per enabled cycle, after every accepted input sample.
module serial_fir_bank #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int TAPS   = 119,
    parameter int NUM_CH = 16,
    parameter int ACC_W  = 39,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int K_W   = $clog2(TAPS)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clk_enable,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    coef_we,
    input  logic [CH_W-1:0]         coef_ch,
    input  logic [K_W-1:0]          coef_idx,
    input  logic [COEF_W-1:0]       coef_data,
    output logic                    out_valid,
    output logic [NUM_CH*ACC_W-1:0] out_data,
    output logic                    busy
);

    localparam int PROD_W = DATA_W + COEF_W;

    typedef enum logic {
        IDLE = 1'b0,
        MAC  = 1'b1
    } state_t;

    state_t                    state_reg;
    logic [K_W-1:0]            k_reg;
    logic                      out_valid_reg;
    logic signed [DATA_W-1:0]  dl_reg [TAPS];

    logic                      last_tap;
    logic                      coef_wr;
    logic signed [DATA_W-1:0]  tap_sample;

    // The tap counter only stops at TAPS-1, so it never indexes past the line.
    assign last_tap   = (k_reg == K_W'(TAPS - 1));
    assign tap_sample = dl_reg[k_reg];

    // Coefficients may only change between MAC passes, and out-of-range
    // addresses are dropped rather than aliased onto a real location.
    assign coef_wr = clk_enable && (state_reg == IDLE) && coef_we
                     && ({1'b0, coef_ch}  < (CH_W + 1)'(NUM_CH))
                     && ({1'b0, coef_idx} < (K_W + 1)'(TAPS));

    assign in_ready  = (state_reg == IDLE) && clk_enable;
    assign busy      = (state_reg == MAC);
    assign out_valid = out_valid_reg;

    // Control FSM: accepts a sample into the delay line, then steps k through all taps.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            k_reg         <= '0;
            out_valid_reg <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                dl_reg[i] <= '0;
            end
        end else if (clk_enable) begin
            out_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        dl_reg[0] <= in_data;
                        for (int i = 1; i < TAPS; i++) begin
                            dl_reg[i] <= dl_reg[i-1];
                        end
                        k_reg     <= '0;
                        state_reg <= MAC;
                    end
                end
                MAC: begin
                    if (last_tap) begin
                        k_reg         <= '0;
                        out_valid_reg <= 1'b1;
                        state_reg     <= IDLE;
                    end else begin
                        k_reg <= k_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic signed [COEF_W-1:0] coef_reg [TAPS];
        logic signed [ACC_W-1:0]  acc_reg;
        logic signed [ACC_W-1:0]  out_reg;
        logic signed [PROD_W-1:0] prod;
        logic signed [ACC_W-1:0]  prod_ext;
        logic signed [ACC_W-1:0]  sum;

        // Full-precision product, sign-extended; ACC_W is sized so the sum cannot wrap.
        assign prod     = tap_sample * coef_reg[k_reg];
        assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
        assign sum      = acc_reg + prod_ext;

        // Per-channel coefficient store; a write on an accept edge lands before tap 0 is read.
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                for (int i = 0; i < TAPS; i++) begin
                    coef_reg[i] <= '0;
                end
            end else if (coef_wr && (coef_ch == CH_W'(gi))) begin
                coef_reg[coef_idx] <= coef_data;
            end
        end

        // Accumulate one tap per enabled MAC cycle; the last tap goes straight to the output.
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                acc_reg <= '0;
                out_reg <= '0;
            end else if (clk_enable) begin
                if (state_reg == IDLE) begin
                    if (in_valid) begin
                        acc_reg <= '0;
                    end
                end else if (last_tap) begin
                    out_reg <= sum;
                end else begin
                    acc_reg <= sum;
                end
            end
        end

        assign out_data[gi*ACC_W +: ACC_W] = out_reg;
    end

endmodule

// File: tb/tb_serial_fir_bank.sv
// Testbench for serial_fir_bank: a reference model of the filter bank pushes
// expected channel results into a queue on every accepted sample; a negedge
// monitor pops and compares them when the DUT strobes out_valid.
module tb_serial_fir_bank;

    localparam int DATA_W = 16;
    localparam int COEF_W = 16;
    localparam int TAPS   = 119;
    localparam int NUM_CH = 16;
    localparam int ACC_W  = 39;
    localparam int OUT_W  = NUM_CH * ACC_W;

    logic              clock;
    logic              reset;
    logic              clk_enable;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              coef_we;
    logic [3:0]        coef_ch;
    logic [6:0]        coef_idx;
    logic [COEF_W-1:0] coef_data;
    logic              out_valid;
    logic [OUT_W-1:0]  out_data;
    logic              busy;

    serial_fir_bank #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .TAPS   (TAPS),
        .NUM_CH (NUM_CH),
        .ACC_W  (ACC_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .clk_enable (clk_enable),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .coef_we    (coef_we),
        .coef_ch    (coef_ch),
        .coef_idx   (coef_idx),
        .coef_data  (coef_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .busy       (busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_res = 0;
    int last_acc = 0;
    bit mon_on = 1'b0;
    bit en_rand = 1'b0;

    // reference model state
    int                       model_cnt = 0;
    logic                     model_ov = 1'b0;
    logic                     en_edge = 1'b0;
    logic signed [DATA_W-1:0] m_dl [TAPS];
    logic signed [COEF_W-1:0] m_coef [NUM_CH][TAPS];
    logic [OUT_W-1:0]         exp_q [$];
    logic [OUT_W-1:0]         m_out = '0;
    logic [OUT_W-1:0]         exp_vec;
    longint                   m_sum;

    task automatic chk(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: direct convolution over its own delay line and coefficient table.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            en_edge   = 1'b0;
            model_cnt = 0;
            model_ov  = 1'b0;
            m_out     = '0;
            exp_q.delete();
            for (int k = 0; k < TAPS; k++) begin
                m_dl[k] = '0;
                for (int c = 0; c < NUM_CH; c++) m_coef[c][k] = '0;
            end
        end else begin
            en_edge = clk_enable;
            cyc++;
            if (clk_enable) begin
                if (model_cnt == 0) begin
                    model_ov = 1'b0;
                    if (coef_we && int'(coef_ch) < NUM_CH && int'(coef_idx) < TAPS)
                        m_coef[coef_ch][coef_idx] = coef_data;
                    if (in_valid) begin
                        for (int k = TAPS - 1; k > 0; k--) m_dl[k] = m_dl[k-1];
                        m_dl[0] = in_data;
                        for (int c = 0; c < NUM_CH; c++) begin
                            m_sum = 0;
                            for (int k = 0; k < TAPS; k++)
                                m_sum += longint'(m_dl[k]) * longint'(m_coef[c][k]);
                            exp_vec[c*ACC_W +: ACC_W] = m_sum[ACC_W-1:0];
                        end
                        exp_q.push_back(exp_vec);
                        model_cnt = TAPS;
                    end
                end else begin
                    model_cnt--;
                    model_ov = (model_cnt == 0);
                end
            end
        end
    end

    // Monitor: handshake/status every cycle, results popped from the scoreboard on each fresh strobe.
    always @(negedge clock) begin
        if (mon_on) begin
            chk("out_valid", OUT_W'(out_valid), OUT_W'(model_ov));
            chk("busy", OUT_W'(busy), OUT_W'(model_cnt != 0));
            chk("in_ready", OUT_W'(in_ready), OUT_W'((model_cnt == 0) && clk_enable));
            if (en_edge && model_ov) begin
                checks++;
                assert (exp_q.size() > 0) else begin
                    errors++;
                    $error("FAIL result_queue observed=unexpected_out_valid expected=no_result");
                end
                if (exp_q.size() > 0) m_out = exp_q.pop_front();
                $display("result %0d ch0=%0d ch1=%0d", n_res,
                         $signed(out_data[ACC_W-1:0]), $signed(out_data[2*ACC_W-1:ACC_W]));
                n_res++;
            end
            chk("out_data", out_data, m_out);
        end
    end

    // Random clock-enable generator, active only while en_rand is set.
    initial begin
        forever begin
            @(posedge clock);
            #2;
            if (en_rand) clk_enable = 1'($urandom_range(0, 1));
        end
    end

    task automatic wr(input int ch, input int idx, input logic [COEF_W-1:0] d);
        coef_we   = 1'b1;
        coef_ch   = 4'(ch);
        coef_idx  = 7'(idx);
        coef_data = d;
        @(posedge clock);
        #2;
        coef_we = 1'b0;
    endtask

    task automatic send(input logic [DATA_W-1:0] d);
        bit acc = 1'b0;
        int t = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!acc && t < 2000) begin
            @(negedge clock);
            acc = in_ready;
            @(posedge clock);
            #2;
            t++;
        end
        last_acc = cyc;
        chk("accept_timeout", OUT_W'(acc), OUT_W'(1));
    endtask

    task automatic drain();
        int t = 0;
        while (model_cnt != 0 && t < 3000) begin
            @(posedge clock);
            #2;
            t++;
        end
        repeat (3) @(posedge clock);
        #2;
    endtask

    initial begin
        int prev;
        reset = 1'b0; clk_enable = 1'b1; in_valid = 1'b0; in_data = '0;
        coef_we = 1'b0; coef_ch = '0; coef_idx = '0; coef_data = '0;

        // reset state
        repeat (3) @(posedge clock);
        #2;
        mon_on = 1'b1;
        @(negedge clock);
        chk("reset_out_data", out_data, '0);
        chk("reset_out_valid", OUT_W'(out_valid), '0);
        chk("reset_busy", OUT_W'(busy), '0);
        @(posedge clock);
        #2;
        reset = 1'b1;
        @(negedge clock);
        chk("ready_after_reset", OUT_W'(in_ready), OUT_W'(1));

        // impulse: ch0 coef[k] = k+1, input 1 followed by zeros
        for (int k = 0; k < TAPS; k++) wr(0, k, COEF_W'(k + 1));
        send(DATA_W'(1));
        for (int i = 0; i < TAPS - 1; i++) send('0);
        in_valid = 1'b0;
        drain();
        chk("impulse_last_ch0", OUT_W'(out_data[ACC_W-1:0]), OUT_W'(TAPS));
        chk("impulse_last_ch1", OUT_W'(out_data[2*ACC_W-1:ACC_W]), '0);

        // worst case: every coefficient and every sample at the most negative value
        for (int c = 0; c < NUM_CH; c++)
            for (int k = 0; k < TAPS; k++) wr(c, k, 16'h8000);
        for (int i = 0; i < TAPS; i++) send(16'h8000);
        in_valid = 1'b0;
        drain();
        for (int c = 0; c < NUM_CH; c++)
            chk($sformatf("worst_ch%0d", c), OUT_W'(out_data[c*ACC_W +: ACC_W]), OUT_W'(39'd127775277056));

        // out-of-range tap writes must be dropped; then some legal random coefficients
        for (int idx = TAPS; idx < 128; idx++) wr($urandom_range(0, NUM_CH - 1), idx, 16'h1234);
        for (int i = 0; i < 40; i++)
            wr($urandom_range(0, NUM_CH - 1), $urandom_range(0, TAPS - 1), COEF_W'($urandom));

        // held in_valid with random data; coefficient writes asserted throughout (busy ones dropped)
        prev = 0;
        for (int i = 0; i < 8; i++) begin
            coef_we   = 1'b1;
            coef_ch   = 4'($urandom_range(0, NUM_CH - 1));
            coef_idx  = 7'($urandom_range(0, 127));
            coef_data = COEF_W'($urandom);
            send(DATA_W'($urandom));
            if (i > 0) chk("accept_spacing", OUT_W'(last_acc - prev), OUT_W'(TAPS + 1));
            prev = last_acc;
        end
        coef_we  = 1'b0;
        in_valid = 1'b0;
        drain();

        // random clock enable during MAC passes
        en_rand = 1'b1;
        for (int i = 0; i < 4; i++) send(DATA_W'($urandom));
        in_valid = 1'b0;
        drain();
        en_rand = 1'b0;
        @(posedge clock);
        #3;
        clk_enable = 1'b1;
        drain();

        // reset pulsed at k=60 aborts the pass
        send(DATA_W'($urandom));
        in_valid = 1'b0;
        repeat (60) @(posedge clock);
        #2;
        reset = 1'b0;
        @(posedge clock);
        #2;
        reset = 1'b1;
        @(negedge clock);
        chk("abort_out_data", out_data, '0);
        chk("abort_in_ready", OUT_W'(in_ready), OUT_W'(1));
        chk("abort_out_valid", OUT_W'(out_valid), '0);
        repeat (200) @(posedge clock);
        #2;

        // coefficients were cleared by reset, so a fresh sample yields zero
        send(16'h7fff);
        in_valid = 1'b0;
        drain();
        chk("post_reset_ch0", OUT_W'(out_data[ACC_W-1:0]), '0);
        chk("queue_empty", OUT_W'(exp_q.size()), '0);

        mon_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
